// File: rtl/key_fifo_if.sv
// Keypad capture / CPU drain signal bundle for key_fifo.
// The slave view belongs to the FIFO; the master view belongs to its environment.
interface key_fifo_if;
  logic [4:0]  Key_out;
  logic        Key_ready;
  logic        readn;
  logic        rd_en;
  logic        clr;
  logic [31:0] key_data;
  logic        key_irq;
  logic        full;
  logic        empty;

  modport master (
    output Key_out, Key_ready, rd_en, clr,
    input  readn, key_data, key_irq, full, empty
  );

  modport slave (
    input  Key_out, Key_ready, rd_en, clr,
    output readn, key_data, key_irq, full, empty
  );
endinterface

// File: rtl/key_fifo.sv
// Captures each debounced keypad code once, acknowledges it with a one-cycle
// readn pulse, and buffers it for the CPU behind a status/data word.
module key_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic       clk,
  input logic       rst,
  key_fifo_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  state_t        state_reg, state_next;
  logic          readn_reg;
  logic [4:0]    mem_reg [DEPTH];
  logic [AW-1:0] wp_reg, rp_reg;
  logic [AW:0]   count_reg, count_next;
  logic          overflow_reg;

  logic          capture;
  logic          push_en;
  logic          pop_en;
  logic          overflow_set;
  logic          full_w;
  logic          empty_w;
  logic [4:0]    head;
  logic [31:0]   key_data_w;

  assign full_w  = (count_reg == FULL_CNT);
  assign empty_w = (count_reg == '0);

  // WAIT holds off re-capture until upstream drops ready, so a slow
  // release never yields a duplicate code.
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.Key_ready) begin
          capture    = 1'b1;
          state_next = ACK;
        end
      end
      ACK:     state_next = WAIT;
      WAIT:    if (!bus.Key_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      readn_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      readn_reg <= (state_reg != ACK);
    end
  end

  // A full FIFO still accepts when the CPU pops in the same cycle.
  assign push_en      = capture && (!full_w || bus.rd_en) && !bus.clr;
  assign pop_en       = bus.rd_en && !empty_w && !bus.clr;
  assign overflow_set = capture && full_w && !bus.rd_en;

  always_comb begin
    count_next = count_reg;
    case ({push_en, pop_en})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      wp_reg       <= '0;
      rp_reg       <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_en) wp_reg <= wp_reg + PTR_ONE;
      if (pop_en)  rp_reg <= rp_reg + PTR_ONE;
      count_reg <= count_next;
      if (overflow_set) overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_reg[wp_reg] <= bus.Key_out;
  end

  // Memory is never reset, so the head is masked while empty.
  assign head = empty_w ? 5'd0 : mem_reg[rp_reg];

  always_comb begin
    key_data_w             = '0;
    key_data_w[31]         = !empty_w;
    key_data_w[30]         = overflow_reg;
    key_data_w[AW+16:16]   = count_reg;
    key_data_w[4:0]        = head;
  end

  assign bus.key_data = key_data_w;
  assign bus.key_irq  = !empty_w;
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.readn    = readn_reg;

endmodule

// File: tb/tb_key_fifo.sv
// Scoreboard bench for key_fifo: a queue model of the FIFO is updated as keys
// are captured and popped, and every DUT output is compared against it.
module tb_key_fifo;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   pulse_cnt = 0;

  logic [4:0] model_q[$];
  logic       model_ovf = 1'b0;

  key_fifo_if bus ();

  key_fifo #(.DEPTH(DEPTH), .AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // readn is low for one full cycle per acknowledge, spanning one falling edge.
  always @(negedge clk) begin
    if (!rst && !bus.readn) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word();
    logic [31:0] w;
    w = '0;
    if (model_q.size() != 0) begin
      w[31]  = 1'b1;
      w[4:0] = model_q[0];
    end
    w[30]    = model_ovf;
    w[19:16] = 4'(model_q.size());
    return w;
  endfunction

  task automatic check_status(input string tag);
    check_eq({tag, "_word"},  bus.key_data, exp_word());
    check_eq({tag, "_irq"},   {31'd0, bus.key_irq}, {31'd0, model_q.size() != 0});
    check_eq({tag, "_full"},  {31'd0, bus.full},    {31'd0, model_q.size() == DEPTH});
    check_eq({tag, "_empty"}, {31'd0, bus.empty},   {31'd0, model_q.size() == 0});
  endtask

  // One capture handshake; ready is held for 'extra' cycles beyond the pulse.
  task automatic press(input logic [4:0] code, input int extra, input logic pop);
    int p0;
    p0 = pulse_cnt;
    if (pop && model_q.size() != 0)
      check_eq("head_before_pop", {27'd0, bus.key_data[4:0]}, {27'd0, model_q[0]});
    bus.Key_out   = code;
    bus.Key_ready = 1'b1;
    bus.rd_en     = pop;
    step();
    bus.rd_en = 1'b0;
    if (pop && model_q.size() != 0) void'(model_q.pop_front());
    if (model_q.size() < DEPTH) model_q.push_back(code);
    else model_ovf = 1'b1;
    check_status("capture");
    check_eq("readn_at_capture", {31'd0, bus.readn}, 32'd1);
    step();
    check_eq("readn_ack", {31'd0, bus.readn}, 32'd0);
    step();
    check_eq("readn_after_ack", {31'd0, bus.readn}, 32'd1);
    repeat (extra) step();
    bus.Key_ready = 1'b0;
    step();
    check_eq("pulse_count", pulse_cnt - p0, 32'd1);
    $display("press code=%0d pop=%0d count=%0d ovf=%0d", code, pop, model_q.size(), model_ovf);
  endtask

  task automatic pop_one();
    if (model_q.size() != 0)
      check_eq("head_before_pop", {27'd0, bus.key_data[4:0]}, {27'd0, model_q[0]});
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    if (model_q.size() != 0) void'(model_q.pop_front());
    check_status("pop");
    $display("pop count=%0d", model_q.size());
  endtask

  initial begin
    int p0;
    bus.Key_out   = '0;
    bus.Key_ready = 1'b0;
    bus.rd_en     = 1'b0;
    bus.clr       = 1'b0;
    rst           = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_eq("reset_readn", {31'd0, bus.readn}, 32'd1);
    check_eq("reset_word", bus.key_data, 32'h0000_0000);
    check_status("reset");
    $display("reset done");

    // Single key held well past its acknowledge.
    press(5'h0A, 3, 1'b0);
    check_eq("single_word", bus.key_data, 32'h8001_000A);
    pop_one();
    check_eq("single_drained", bus.key_data, 32'h0000_0000);

    // Fill to DEPTH, ninth code overflows but is still acknowledged.
    p0 = pulse_cnt;
    for (int c = 1; c <= 9; c++) press(5'(c), 0, 1'b0);
    check_eq("fill_pulses", pulse_cnt - p0, 32'd9);
    check_eq("fill_full", {31'd0, bus.full}, 32'd1);
    check_eq("fill_ovf", {31'd0, bus.key_data[30]}, 32'd1);
    check_eq("fill_count", {28'd0, bus.key_data[19:16]}, 32'd8);
    check_eq("fill_head", {27'd0, bus.key_data[4:0]}, 32'd1);

    // Capture and pop together while full.
    press(5'd10, 0, 1'b1);
    check_eq("pp_count", {28'd0, bus.key_data[19:16]}, 32'd8);
    check_eq("pp_head", {27'd0, bus.key_data[4:0]}, 32'd2);
    check_eq("pp_ovf", {31'd0, bus.key_data[30]}, 32'd1);
    for (int i = 0; i < DEPTH; i++) pop_one();

    // Flush on the cycle after a capture; the acknowledge still completes.
    p0 = pulse_cnt;
    bus.Key_out   = 5'h15;
    bus.Key_ready = 1'b1;
    step();
    check_eq("clr_captured", {28'd0, bus.key_data[19:16]}, 32'd1);
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    check_eq("clr_readn_low", {31'd0, bus.readn}, 32'd0);
    check_status("clr");
    bus.Key_ready = 1'b0;
    step();
    check_eq("clr_readn_high", {31'd0, bus.readn}, 32'd1);
    step();
    check_eq("clr_pulses", pulse_cnt - p0, 32'd1);
    $display("clr during ack done");
    press(5'h1F, 0, 1'b0);
    pop_one();

    // Pop on empty leaves everything unchanged.
    pop_one();
    pop_one();
    check_eq("empty_pop_word", bus.key_data, 32'h0000_0000);

    // Push/pop pairs walk the pointers round several times.
    for (int i = 0; i < 20; i++) begin
      press(5'($urandom_range(31)), 0, 1'b0);
      if (i % 3 == 0) press(5'(i + 3), 0, 1'b0);
      pop_one();
    end
    while (model_q.size() != 0) pop_one();
    check_eq("final_word", bus.key_data, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
